// File: rtl/risc_spm_pkg.sv
// Shared opcodes, controller state encoding and Bus_2 select codes for the SPM RISC control unit.
// Optional feature macro: RISC_SPM_ILLEGAL_TRAP_EN (illegal opcodes halt the core).
package risc_spm_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_RD   = 4'h5;
  localparam logic [3:0] OP_WR   = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_t;

  function automatic logic op_is_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_BRZ) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/risc_spm_ctrl_p_if.sv
// Control-unit bundle: instruction/flag inputs, datapath strobes, memory handshake and debug state.
// Optional feature macro: RISC_SPM_ILLEGAL_TRAP_EN (drives the illegal flag).
interface risc_spm_ctrl_p_if #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 4,
  parameter int SEL1_SIZE = $clog2(NUM_REGS + 1),
  parameter int SEL2_SIZE = 2
);
  logic [WORD_SIZE-1:0] instruction;
  logic                 zero;
  // mem_ready is a one-cycle "access done" qualifier: a waiting state holds its
  // selects (and write) with every load/inc strobe low, and fires them exactly
  // in the cycle mem_ready is high; no other handshake exists.
  logic                 mem_ready;
  logic [NUM_REGS-1:0]  load_reg;
  logic                 load_pc;
  logic                 inc_pc;
  logic [SEL1_SIZE-1:0] sel_bus_1_mux;
  logic [SEL2_SIZE-1:0] sel_bus_2_mux;
  logic                 load_ir;
  logic                 load_add_r;
  logic                 load_reg_y;
  logic                 load_reg_z;
  logic                 write;
  logic                 halted;
  logic                 illegal;
  risc_spm_pkg::state_t state;

  modport master (
    input  instruction, zero, mem_ready,
    output load_reg, load_pc, inc_pc, sel_bus_1_mux, sel_bus_2_mux,
           load_ir, load_add_r, load_reg_y, load_reg_z, write, halted, illegal, state
  );

  modport slave (
    output instruction, zero, mem_ready,
    input  load_reg, load_pc, inc_pc, sel_bus_1_mux, sel_bus_2_mux,
           load_ir, load_add_r, load_reg_y, load_reg_z, write, halted, illegal, state
  );
endinterface

// File: rtl/risc_spm_decode.sv
// Combinational split of the IR into opcode and register fields plus opcode class flags.
module risc_spm_decode
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4,
  parameter int REG_SEL   = 2
) (
  input  logic [WORD_SIZE-1:0] instruction,
  output logic [OP_SIZE-1:0]   opcode,
  output logic [REG_SEL-1:0]   src,
  output logic [REG_SEL-1:0]   dest,
  output logic                 is_alu,
  output logic                 is_legal
);
  localparam int LOW = WORD_SIZE - OP_SIZE - 2 * REG_SEL;

  logic [3:0] op_low;
  logic       op_high_zero;

  assign opcode = instruction[WORD_SIZE-1 -: OP_SIZE];
  assign src    = instruction[WORD_SIZE-OP_SIZE-1 -: REG_SEL];
  assign dest   = instruction[WORD_SIZE-OP_SIZE-REG_SEL-1 -: REG_SEL];

  // Wider opcode fields are legal only when the bits above the 4-bit ISA are zero.
  assign op_low       = opcode[3:0];
  assign op_high_zero = (opcode >> 4) == '0;
  assign is_alu       = op_high_zero && op_is_alu(op_low);
  assign is_legal     = op_high_zero && op_is_legal(op_low);

  generate
    if (LOW > 0) begin : g_pad
      logic unused_low;
      assign unused_low = ^instruction[LOW-1:0];
    end
  endgenerate
endmodule

// File: rtl/risc_spm_ctrl_p.sv
// Multi-cycle SPM RISC controller with mem_ready wait states and a halted status.
// Optional feature macro: RISC_SPM_ILLEGAL_TRAP_EN (illegal opcode -> S_HALT, sticky illegal flag).
module risc_spm_ctrl_p
  import risc_spm_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 4,
  parameter int OP_SIZE   = 4,
  parameter int SEL1_SIZE = $clog2(NUM_REGS + 1),
  parameter int SEL2_SIZE = 2
) (
  input logic               clk,
  input logic               rst,
  risc_spm_ctrl_p_if.master bus
);
  localparam int REG_SEL = $clog2(NUM_REGS);
  localparam logic [SEL1_SIZE-1:0] SEL1_PC = SEL1_SIZE'(NUM_REGS);

  generate
    if (OP_SIZE + 2 * REG_SEL > WORD_SIZE || OP_SIZE < 4 || NUM_REGS < 2) begin : g_bad_params
      $error("risc_spm_ctrl_p: instruction fields do not fit WORD_SIZE");
    end
  endgenerate

  state_t               state, next;
  logic [OP_SIZE-1:0]   opcode;
  logic [REG_SEL-1:0]   src, dest;
  logic                 is_alu, is_legal;
  logic [NUM_REGS-1:0]  load_reg;
  logic [SEL1_SIZE-1:0] sel1;
  logic [SEL2_SIZE-1:0] sel2;
  logic load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write;

  risc_spm_decode #(.WORD_SIZE(WORD_SIZE), .OP_SIZE(OP_SIZE), .REG_SEL(REG_SEL)) u_decode (
    .instruction(bus.instruction), .opcode(opcode), .src(src), .dest(dest),
    .is_alu(is_alu), .is_legal(is_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    load_reg   = '0;
    sel1       = '0;
    sel2       = '0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write      = 1'b0;
    unique case (state)
      S_IDLE: next = S_FET1;
      S_FET1: begin
        sel1 = SEL1_PC; sel2 = SEL2_SIZE'(SEL2_BUS1); load_add_r = 1'b1; next = S_FET2;
      end
      S_FET2: begin
        sel2 = SEL2_SIZE'(SEL2_MEM);
        if (bus.mem_ready) begin load_ir = 1'b1; inc_pc = 1'b1; next = S_DEC; end
      end
      S_DEC: begin
        next = S_FET1;
        if (!is_legal) begin
`ifdef RISC_SPM_ILLEGAL_TRAP_EN
          next = S_HALT;
`else
          next = S_FET1;
`endif
        end else if (is_alu) begin
          sel1 = SEL1_SIZE'(src); sel2 = SEL2_SIZE'(SEL2_BUS1); load_reg_y = 1'b1; next = S_EX1;
        end else begin
          case (opcode)
            OP_SIZE'(OP_NOT): begin
              sel1 = SEL1_SIZE'(src); sel2 = SEL2_SIZE'(SEL2_ALU);
              load_reg_z = 1'b1; load_reg = NUM_REGS'(1) << dest;
            end
            OP_SIZE'(OP_RD), OP_SIZE'(OP_WR), OP_SIZE'(OP_BR), OP_SIZE'(OP_BRZ): begin
              if (opcode == OP_SIZE'(OP_BRZ) && !bus.zero) begin
                inc_pc = 1'b1;  // skip the unused branch-target word
              end else begin
                sel1 = SEL1_PC; sel2 = SEL2_SIZE'(SEL2_BUS1); load_add_r = 1'b1;
                if (opcode == OP_SIZE'(OP_RD))      next = S_RD1;
                else if (opcode == OP_SIZE'(OP_WR)) next = S_WR1;
                else                                next = S_BR1;
              end
            end
            OP_SIZE'(OP_HALT): next = S_HALT;
            default:           next = S_FET1;
          endcase
        end
      end
      S_EX1: begin
        sel1 = SEL1_SIZE'(dest); sel2 = SEL2_SIZE'(SEL2_ALU);
        load_reg_z = 1'b1; load_reg = NUM_REGS'(1) << dest; next = S_FET1;
      end
      S_RD1, S_WR1: begin
        sel2 = SEL2_SIZE'(SEL2_MEM);
        if (bus.mem_ready) begin
          load_add_r = 1'b1; inc_pc = 1'b1;
          next = (state == S_RD1) ? S_RD2 : S_WR2;
        end
      end
      S_RD2: begin
        sel2 = SEL2_SIZE'(SEL2_MEM);
        if (bus.mem_ready) begin load_reg = NUM_REGS'(1) << dest; next = S_FET1; end
      end
      S_WR2: begin
        sel1 = SEL1_SIZE'(src); write = 1'b1;
        if (bus.mem_ready) next = S_FET1;
      end
      S_BR1: begin
        sel2 = SEL2_SIZE'(SEL2_MEM);
        if (bus.mem_ready) begin load_add_r = 1'b1; next = S_BR2; end
      end
      S_BR2: begin
        sel2 = SEL2_SIZE'(SEL2_MEM);
        if (bus.mem_ready) begin load_pc = 1'b1; next = S_FET1; end
      end
      S_HALT:  next = S_HALT;
      default: next = S_IDLE;
    endcase
  end

`ifdef RISC_SPM_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           illegal_q <= 1'b0;
    else if (state == S_DEC && !is_legal) illegal_q <= 1'b1;
  end
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.load_reg      = load_reg;
  assign bus.load_pc       = load_pc;
  assign bus.inc_pc        = inc_pc;
  assign bus.sel_bus_1_mux = sel1;
  assign bus.sel_bus_2_mux = sel2;
  assign bus.load_ir       = load_ir;
  assign bus.load_add_r    = load_add_r;
  assign bus.load_reg_y    = load_reg_y;
  assign bus.load_reg_z    = load_reg_z;
  assign bus.write         = write;
  assign bus.halted        = (state == S_HALT);
  assign bus.state         = state;
endmodule
